// File: rtl/spi_slave_rx.sv
// Purpose: SPI mode-0 slave receiver; oversamples CS/SCLK/MOSI in clk and deserialises F_SIZE-bit MSB-first frames.
// Latency: rx_data/rx_valid update 2 clk edges after the synchroniser first captures SCLK=1 for the last bit.
// Backpressure: a frame completing while rx_valid=1 and rx_ready=0 is dropped and sets sticky overrun.
// Build option: define SPI_SLAVE_MISO_EN to enable the MISO reply path (tx_data/tx_ack); otherwise MISO and tx_ack are tied 0.
module spi_slave_rx #(
   parameter int F_SIZE  = 8,
   parameter int C_SIZE  = $clog2(F_SIZE) + 1,
   parameter int FC_SIZE = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               CS,
   input  logic               SCLK,
   input  logic               MOSI,
   output logic               MISO,
   output logic [F_SIZE-1:0]  rx_data,
   output logic               rx_valid,
   input  logic               rx_ready,
   input  logic [F_SIZE-1:0]  tx_data,
   output logic               tx_ack,
   output logic               overrun,
   output logic               frame_err,
   output logic [FC_SIZE-1:0] frame_cnt,
   output logic               busy
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   logic              cs_s1, cs_s2, cs_s3;
   logic              sclk_s1, sclk_s2, sclk_s3;
   logic              mosi_s1, mosi_s2;
   logic [0:0]        state;
   logic [C_SIZE-1:0] bit_cnt;
   logic [F_SIZE-2:0] shift_reg;

   logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic              in_active, last_bit, frame_done;
   logic [F_SIZE-1:0] frame_word;

   // Bring the asynchronous SPI pins into clk; the third stage gives edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_s3   <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         cs_s1   <= CS;
         cs_s2   <= cs_s1;
         cs_s3   <= cs_s2;
         sclk_s1 <= SCLK;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         mosi_s1 <= MOSI;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise  = sclk_s2 & ~sclk_s3;
   assign sclk_fall  = ~sclk_s2 & sclk_s3;
   assign cs_fall    = ~cs_s2 & cs_s3;
   assign cs_rise    = cs_s2 & ~cs_s3;
   assign in_active  = (state == ACTIVE);
   assign last_bit   = (bit_cnt == C_SIZE'(F_SIZE - 1));
   // A rising SCLK that coincides with CS going high belongs to no frame.
   assign frame_done = in_active & ~cs_rise & sclk_rise & last_bit;
   assign frame_word = {shift_reg, mosi_s2};
   assign busy       = in_active;

   // Frame FSM: track CS, shift MOSI on SCLK rise, flag frames cut short by CS.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state   <= ACTIVE;
                  bit_cnt <= '0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  frame_err <= (bit_cnt != '0);
               end else if (sclk_rise) begin
                  shift_reg <= frame_word[F_SIZE-2:0];
                  bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output holding register with valid/ready handshake, drop-on-full and frame counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (frame_done) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (!rx_valid || rx_ready) begin
               rx_data  <= frame_word;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_MISO_EN
   logic [F_SIZE-1:0] tx_shift;
   logic              skip_fall;

   // Reply shifter: load at CS fall and at each frame end, shift on SCLK fall.
   // The SCLK fall that trails the last bit of a frame must not consume the MSB
   // of the reply just loaded for the next frame, so that one fall is skipped.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_shift  <= '0;
         skip_fall <= 1'b0;
         tx_ack    <= 1'b0;
      end else begin
         tx_ack <= 1'b0;
         if (!in_active && cs_fall) begin
            tx_shift  <= tx_data;
            tx_ack    <= 1'b1;
            skip_fall <= 1'b0;
         end else if (frame_done) begin
            tx_shift  <= tx_data;
            tx_ack    <= 1'b1;
            skip_fall <= 1'b1;
         end else if (in_active && sclk_fall) begin
            if (skip_fall) begin
               skip_fall <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[F_SIZE-2:0], 1'b0};
            end
         end
      end
   end

   assign MISO = in_active & tx_shift[F_SIZE-1];
`else
   logic unused_tx_data;

   assign unused_tx_data = ^tx_data;
   assign MISO           = 1'b0;
   assign tx_ack         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

   logic       clk = 1'b0;
   logic       rst, CS, SCLK, MOSI, MISO;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic [7:0] tx_data;
   logic       tx_ack, overrun, frame_err, busy;
   logic [7:0] frame_cnt;

   spi_slave_rx #(.F_SIZE(8), .FC_SIZE(8)) dut (
      .clk(clk), .rst(rst), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_ack(tx_ack), .overrun(overrun),
      .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int err_cnt = 0;
   int ack_cnt = 0;
   int xfer_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted frame is compared with the oldest expected one.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) err_cnt++;
         if (tx_ack) ack_cnt++;
         if (rx_valid && rx_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got frame %0h, required none", rx_data);
            end else begin
               check("sb_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic cs_low();
      CS = 1'b0;
      tick(6);
   endtask

   task automatic cs_high();
      CS = 1'b1;
      tick(6);
   endtask

   // Master: SCLK = clk/8, MOSI set while SCLK low, MISO sampled at each rising SCLK.
   task automatic shift_bits(input logic [7:0] d, input int n, input bit ready_on_last,
                             output logic [7:0] miso_cap);
      miso_cap = 8'h00;
      for (int i = 0; i < n; i++) begin
         MOSI = d[7-i];
         tick(4);
         SCLK = 1'b1;
         miso_cap = {miso_cap[6:0], MISO};
         if (ready_on_last && i == n - 1) begin
            tick(2);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            tick(1);
         end else begin
            tick(4);
         end
         SCLK = 1'b0;
      end
      tick(4);
   endtask

   initial begin
      logic [7:0] cap;
      int e0, a0, x0;
      logic [7:0] exp_miso;
      int exp_ack;
`ifdef SPI_SLAVE_MISO_EN
      exp_miso = 8'h3C;
      exp_ack  = 2;
`else
      exp_miso = 8'h00;
      exp_ack  = 0;
`endif
      rst = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; rx_ready = 1'b0; tx_data = 8'h00;
      tick(3);
      rst = 1'b0;
      tick(1);

      // Reset state
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_miso", MISO, 0);
      check("rst_tx_ack", tx_ack, 0);
      check("rst_frame_err", frame_err, 0);

      // Single frame 0xA5 with reply 0x3C
      do_reset();
      rx_ready = 1'b1;
      tx_data  = 8'h3C;
      a0 = ack_cnt;
      x0 = xfer_cnt;
      exp_q.push_back(8'hA5);
      cs_low();
      check("single_busy", busy, 1);
      shift_bits(8'hA5, 8, 1'b0, cap);
      cs_high();
      check("single_busy_end", busy, 0);
      check("single_xfers", xfer_cnt - x0, 1);
      check("single_frame_cnt", frame_cnt, 1);
      check("single_overrun", overrun, 0);
      check("single_rx_valid", rx_valid, 0);
      check("reply_miso", cap, exp_miso);
      check("reply_tx_ack", ack_cnt - a0, exp_ack);

      // Back-to-back with consumer stalled: second frame dropped
      do_reset();
      rx_ready = 1'b0;
      exp_q.push_back(8'h12);
      cs_low();
      shift_bits(8'h12, 8, 1'b0, cap);
      shift_bits(8'h34, 8, 1'b0, cap);
      cs_high();
      check("b2b_rx_valid", rx_valid, 1);
      check("b2b_rx_data", rx_data, 8'h12);
      check("b2b_overrun", overrun, 1);
      check("b2b_frame_cnt", frame_cnt, 2);
      rx_ready = 1'b1;
      tick(1);
      check("b2b_valid_clear", rx_valid, 0);
      check("b2b_overrun_sticky", overrun, 1);

      // Abort after 5 bits, then a full 0xFF frame
      do_reset();
      rx_ready = 1'b1;
      e0 = err_cnt;
      cs_low();
      shift_bits(8'hB7, 5, 1'b0, cap);
      cs_high();
      check("abort_frame_err", err_cnt - e0, 1);
      check("abort_rx_valid", rx_valid, 0);
      check("abort_frame_cnt", frame_cnt, 0);
      exp_q.push_back(8'hFF);
      cs_low();
      shift_bits(8'hFF, 8, 1'b0, cap);
      cs_high();
      check("abort_next_cnt", frame_cnt, 1);
      check("abort_err_once", err_cnt - e0, 1);

      // Frame 0x55 completes on the exact cycle 0xAA is accepted
      do_reset();
      rx_ready = 1'b0;
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      cs_low();
      shift_bits(8'hAA, 8, 1'b0, cap);
      shift_bits(8'h55, 8, 1'b1, cap);
      cs_high();
      check("simul_rx_data", rx_data, 8'h55);
      check("simul_rx_valid", rx_valid, 1);
      check("simul_overrun", overrun, 0);
      check("simul_frame_cnt", frame_cnt, 2);
      rx_ready = 1'b1;
      tick(2);

      // Reset after 4 bits with CS held low, then full 0xC3 frame
      do_reset();
      e0 = err_cnt;
      cs_low();
      shift_bits(8'h9E, 4, 1'b0, cap);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rstmid_frame_cnt0", frame_cnt, 0);
      tick(2);
      exp_q.push_back(8'hC3);
      shift_bits(8'hC3, 8, 1'b0, cap);
      cs_high();
      check("rstmid_frame_cnt", frame_cnt, 1);
      check("rstmid_no_err", err_cnt - e0, 0);
      check("rstmid_overrun", overrun, 0);

      tick(4);
      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
